data_ram_ctrl: RTL and testbench

Data-memory responder on the load/store port of the 5-stage MIPS pipeline. It accepts the memory stage's request signals (enable, write enable, address, byte select, store data) and performs word reads or byte-masked writes on an internal synchronous RAM after a programmable number of wait states. While an access is in flight it raises a stall request to the pipeline control, and it signals completion with a one-cycle ack.

---
 rtl/data_ram_ctrl.sv | 107 ++++++++++
 tb/tb_data_ram_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: load/store port responder with programmable wait states.
// Ports: clk, rst (sync, active-high); mem_ce_i/we_i/addr_i/sel_i/data_i
//        request; mem_data_o load data; mem_ack_o done; stallreq_o stall.
module data_ram_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        stallreq_o
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [31:0]       data_q;
  logic              ack_q;

  logic [31:0]       ram [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              access;
  logic              wr_en;

  // Byte offset and high address bits are dropped, so the RAM aliases.
  assign idx = mem_addr_i[ADDR_W+1:2];

  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  // The access edge: last wait state elapsed and request still alive.
  assign access = (state_q == BUSY) && mem_ce_i && (cnt_q == 4'd0);

  // rst gates the write so a reset on the access edge drops it.
  assign wr_en = access & mem_we_i & ~rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_sel_i[i]) begin
          ram[idx][8*i +: 8] <= mem_data_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'd0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_ce_i) begin
            cnt_q   <= WAIT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!mem_ce_i) begin
            // Pipeline flush: drop the access.
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Full word on loads; the memory stage picks lanes.
            if (!mem_we_i) begin
              data_q <= ram[idx];
            end
            state_q <= DONE;
            ack_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_data_o = data_q;
  assign mem_ack_o  = ack_q;

  // Released in the ack cycle so the pipeline advances with the data.
  assign stallreq_o = mem_ce_i & ~rst & (state_q != DONE);

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: directed checks of data_ram_ctrl.
// Three instances: WAIT_CYCLES 1 (main), 0 and 5.
module tb_data_ram_ctrl;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       ce;
  logic             we;
  logic [31:0]      addr;
  logic [3:0]       sel;
  logic [31:0]      wd;
  logic [2:0][31:0] dout;
  logic [2:0]       ack;
  logic [2:0]       stall;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int last_ack = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_ctrl #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we),
    .mem_addr_i(addr), .mem_sel_i(sel), .mem_data_i(wd),
    .mem_data_o(dout[0]), .mem_ack_o(ack[0]), .stallreq_o(stall[0])
  );

  data_ram_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we),
    .mem_addr_i(addr), .mem_sel_i(sel), .mem_data_i(wd),
    .mem_data_o(dout[1]), .mem_ack_o(ack[1]), .stallreq_o(stall[1])
  );

  data_ram_ctrl #(.ADDR_W(10), .WAIT_CYCLES(5)) u_w5 (
    .clk(clk), .rst(rst), .mem_ce_i(ce[2]), .mem_we_i(we),
    .mem_addr_i(addr), .mem_sel_i(sel), .mem_data_i(wd),
    .mem_data_o(dout[2]), .mem_ack_o(ack[2]), .stallreq_o(stall[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance d and hold it until ack.
  // Cycle 0 is the cycle the request is first presented.
  task automatic req(input int d, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] dat,
                     output int ack_c, output int st_n,
                     output logic [31:0] rd);
    we    = w;
    addr  = a;
    sel   = s;
    wd    = dat;
    ce[d] = 1'b1;
    ack_c = -1;
    st_n  = 0;
    rd    = 32'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall[d]) st_n++;
      if (ack[d]) begin
        ack_c    = c;
        rd       = dout[d];
        last_ack = cyc;
      end
      step();
      if (ack_c >= 0) break;
    end
    ce[d] = 1'b0;
  endtask

  int          ac;
  int          sn;
  int          t1;
  logic [31:0] rd;
  logic        seen;

  initial begin
    rst  = 1'b1;
    ce   = 3'b000;
    we   = 1'b0;
    addr = 32'd0;
    sel  = 4'd0;
    wd   = 32'd0;
    step();
    step();
    rst = 1'b0;

    // Idle with other inputs toggling.
    for (int i = 0; i < 10; i++) begin
      we   = i[0];
      addr = 32'(i * 32'h44);
      sel  = 4'(i);
      wd   = ~32'(i);
      @(negedge clk);
      chk("idle_data", dout[0], 32'd0);
      chk("idle_ack", 32'(ack), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
      step();
    end

    // Word store then load.
    req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, ac, sn, rd);
    chk("st_ack_cyc", 32'(ac), 32'd3);
    chk("st_stall_n", 32'(sn), 32'd3);
    @(negedge clk);
    chk("ack_one_cyc", 32'(ack[0]), 32'd0);
    step();
    req(0, 1'b0, 32'h10, 4'h0, 32'd0, ac, sn, rd);
    chk("ld_ack_cyc", 32'(ac), 32'd3);
    chk("ld_data", rd, 32'hDEADBEEF);

    // Byte-masked stores.
    req(0, 1'b1, 32'h20, 4'hF, 32'h11223344, ac, sn, rd);
    req(0, 1'b1, 32'h20, 4'b0100, 32'hAABBCCDD, ac, sn, rd);
    req(0, 1'b0, 32'h20, 4'hF, 32'd0, ac, sn, rd);
    chk("mask_lane2", rd, 32'h11BB3344);
    req(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, ac, sn, rd);
    chk("sel0_ack", 32'(ac), 32'd3);
    req(0, 1'b0, 32'h20, 4'hF, 32'd0, ac, sn, rd);
    chk("sel0_keep", rd, 32'h11BB3344);

    // Wait-state sweep.
    req(1, 1'b1, 32'h8, 4'hF, 32'hCAFEF00D, ac, sn, rd);
    chk("w0_st_ack", 32'(ac), 32'd2);
    chk("w0_st_stall", 32'(sn), 32'd2);
    req(1, 1'b0, 32'h8, 4'hF, 32'd0, ac, sn, rd);
    chk("w0_ld_ack", 32'(ac), 32'd2);
    chk("w0_ld_data", rd, 32'hCAFEF00D);
    req(2, 1'b1, 32'hC, 4'hF, 32'h600DF00D, ac, sn, rd);
    chk("w5_st_ack", 32'(ac), 32'd7);
    chk("w5_st_stall", 32'(sn), 32'd7);
    req(2, 1'b0, 32'hC, 4'hF, 32'd0, ac, sn, rd);
    chk("w5_ld_ack", 32'(ac), 32'd7);
    chk("w5_ld_data", rd, 32'h600DF00D);

    // Abort by dropping ce in cycle 1.
    req(0, 1'b1, 32'h30, 4'hF, 32'h0BADC0DE, ac, sn, rd);
    we    = 1'b1;
    addr  = 32'h30;
    sel   = 4'hF;
    wd    = 32'hFFFFFFFF;
    ce[0] = 1'b1;
    @(negedge clk);
    chk("abort_stall", 32'(stall[0]), 32'd1);
    step();
    ce[0] = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack[0]) seen = 1'b1;
      step();
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    chk("abort_hold", dout[0], 32'h11BB3344);
    req(0, 1'b0, 32'h30, 4'hF, 32'd0, ac, sn, rd);
    chk("abort_word", rd, 32'h0BADC0DE);

    // Reset in cycle 1 of a store; ce held into cycle 2.
    we    = 1'b1;
    addr  = 32'h30;
    sel   = 4'hF;
    wd    = 32'h12345678;
    ce[0] = 1'b1;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(stall[0]), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", dout[0], 32'd0);
    chk("rst_ack", 32'(ack[0]), 32'd0);
    step();
    ce[0] = 1'b0;
    step();
    step();
    req(0, 1'b0, 32'h30, 4'hF, 32'd0, ac, sn, rd);
    chk("rst_no_write", rd, 32'h0BADC0DE);

    // Aliasing: 0x1004 maps to word 1.
    req(0, 1'b1, 32'h00001004, 4'b0001, 32'h00000055, ac, sn, rd);
    req(0, 1'b0, 32'h00000004, 4'hF, 32'd0, ac, sn, rd);
    chk("alias_lo", 32'(rd[7:0]), 32'h55);
    req(0, 1'b0, 32'h00000007, 4'hF, 32'd0, ac, sn, rd);
    chk("alias_off", 32'(rd[7:0]), 32'h55);

    // Back-to-back loads.
    req(0, 1'b0, 32'h10, 4'hF, 32'd0, ac, sn, rd);
    t1 = last_ack;
    req(0, 1'b0, 32'h10, 4'hF, 32'd0, ac, sn, rd);
    chk("b2b_gap_w1", 32'(last_ack - t1), 32'd4);
    chk("b2b_data", rd, 32'hDEADBEEF);
    req(2, 1'b0, 32'hC, 4'hF, 32'd0, ac, sn, rd);
    t1 = last_ack;
    req(2, 1'b0, 32'hC, 4'hF, 32'd0, ac, sn, rd);
    chk("b2b_gap_w5", 32'(last_ack - t1), 32'd8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
